imm_builder: RTL and testbench

Parametrised immediate builder for the stack processor's decode stage. Accepts a stream of `IN_W`-bit immediate chunks over a valid/ready handshake. Each chunk either continues the immediate (prefix) or terminates it (final). The block accumulates chunks into an `OUT_W`-bit value, sign- or zero-extended per request, and presents it on a registered output handshake. It replaces the fixed 12→16 sign extender with a multi-chunk, mode-selectable, back-pressured unit.

---
 rtl/imm_builder_pkg.sv | 23 ++
 rtl/imm_builder_sign_zero_ext.sv | 23 ++
 rtl/imm_builder.sv | 145 ++++++++++++++
 tb/tb_imm_builder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_builder_pkg.sv
// imm_builder_pkg
//   Shared types and constants for the immediate builder.
//   - imm_state_e : builder FSM states
//   - EXT_ZERO / EXT_SIGN : extension mode encodings
//   - cnt_width() : chunk-counter width for a given MAX_CHUNKS,
//                   i.e. $clog2(MAX_CHUNKS+1)
package imm_builder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } imm_state_e;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  // The counter must be able to hold MAX_CHUNKS itself.
  function automatic int cnt_width(input int max_chunks);
    return $clog2(max_chunks + 1);
  endfunction

endpackage

// File: rtl/imm_builder_sign_zero_ext.sv
// sign_zero_ext
//   Combinational IN_W -> OUT_W extender, sign or zero fill by mode.
//   Ports:
//     in          [IN_W-1:0]  value to extend
//     signed_mode 1           EXT_SIGN = replicate MSB, EXT_ZERO = fill 0
//     out         [OUT_W-1:0] extended value
module sign_zero_ext
  import imm_builder_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in,
  input  logic             signed_mode,
  output logic [OUT_W-1:0] out
);

  logic w_fill;

  assign w_fill = (signed_mode == EXT_SIGN) ? in[IN_W-1] : 1'b0;
  assign out    = {{(OUT_W-IN_W){w_fill}}, in};

endmodule

// File: rtl/imm_builder.sv
// imm_builder
//   Assembles a multi-chunk immediate from a valid/ready chunk stream
//   and presents it on a registered valid/ready output.
//   Optional feature macro: IMM_BUILDER_OVF_EN enables lost-bit and
//   forced-termination flagging on out_ovf; otherwise out_ovf is 0.
//   Ports:
//     clk, rst_n           clock, synchronous active-low reset
//     in_valid/in_ready    chunk handshake
//     in_data [IN_W-1:0]   chunk bits
//     in_prefix            1 = more chunks follow
//     in_signed            extension mode, taken from the first chunk
//     out_valid/out_ready  result handshake
//     out_data [OUT_W-1:0] assembled immediate
//     out_ovf              overflow / forced-termination flag
//
//   state    | meaning
//   ST_IDLE  | no chunk held, waiting for first chunk
//   ST_ACCUM | one or more chunks held, more expected
//   ST_HOLD  | result valid, waiting for out_ready
module imm_builder
  import imm_builder_pkg::*;
#(
  parameter int IN_W       = 12,
  parameter int OUT_W      = 16,
  parameter int MAX_CHUNKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_prefix,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int CNT_W = cnt_width(MAX_CHUNKS);

  imm_state_e       r_state;
  imm_state_e       w_state_nxt;
  logic [OUT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [OUT_W-1:0] w_ext;
  logic [OUT_W-1:0] w_shifted;
  logic             w_accept;
  logic             w_forced;
  logic             w_term;
  logic             w_out_hs;

  sign_zero_ext #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .in          (in_data),
    .signed_mode (in_signed),
    .out         (w_ext)
  );

  // in_ready depends on state only, never on out_ready.
  assign in_ready  = (r_state != ST_HOLD);
  assign w_accept  = in_valid && in_ready;
  assign w_out_hs  = (r_state == ST_HOLD) && out_ready;
  assign w_cnt_nxt = (r_state == ST_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
  // A prefix chunk that reaches the limit is forced to be final.
  assign w_forced  = in_prefix && (w_cnt_nxt == CNT_W'(MAX_CHUNKS));
  assign w_term    = !in_prefix || w_forced;
  assign w_shifted = {r_acc[OUT_W-IN_W-1:0], in_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (w_accept) begin
          w_state_nxt = w_term ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= (r_state == ST_IDLE) ? w_ext : w_shifted;
      r_cnt <= w_cnt_nxt;
    end else if (w_out_hs) begin
      r_cnt <= '0;
    end
  end

  assign out_valid = (r_state == ST_HOLD);
  assign out_data  = out_valid ? r_acc : '0;

`ifdef IMM_BUILDER_OVF_EN
  logic            r_mode;
  logic            r_ovf;
  logic [IN_W-1:0] w_lost;
  logic            w_lost_bad;

  // Bits pushed off the top must be pure extension of the kept value.
  assign w_lost     = r_acc[OUT_W-1:OUT_W-IN_W];
  assign w_lost_bad = (r_mode == EXT_SIGN) ? (w_lost != {IN_W{w_shifted[OUT_W-1]}})
                                           : (w_lost != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode <= EXT_ZERO;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      if (r_state == ST_IDLE) begin
        r_mode <= in_signed;
        r_ovf  <= w_forced;
      end else begin
        r_ovf  <= r_ovf || w_lost_bad || w_forced;
      end
    end else if (w_out_hs) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_ovf = out_valid && r_ovf;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_imm_builder.sv
// tb_imm_builder
//   Directed-vector bench for imm_builder with default parameters
//   (IN_W=12, OUT_W=16, MAX_CHUNKS=2). Expected out_ovf follows
//   whether IMM_BUILDER_OVF_EN is defined for the build.
module tb_imm_builder;

  localparam int IN_W       = 12;
  localparam int OUT_W      = 16;
  localparam int MAX_CHUNKS = 2;
`ifdef IMM_BUILDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_prefix;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;

  imm_builder #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .MAX_CHUNKS (MAX_CHUNKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_prefix (in_prefix),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d0;
    logic        p0;
    logic        s;
    int          n;
    logic [11:0] d1;
    logic        p1;
    int          gap;
    logic [15:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[11];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    check({tag, "_rdy0"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = v.d0;
    in_prefix = v.p0;
    in_signed = v.s;
    step();
    in_valid  = 1'b0;
    in_data   = 12'hA5A;
    in_prefix = ~v.p0;
    in_signed = ~v.s;
    if (v.n == 2) begin
      check({tag, "_mid_ov"}, 32'(out_valid), 32'd0);
      for (int g = 0; g < v.gap; g++) begin
        step();
        check({tag, "_gap_ov"}, 32'(out_valid), 32'd0);
      end
      check({tag, "_rdy1"}, 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      in_data   = v.d1;
      in_prefix = v.p1;
      in_signed = ~v.s;   // must be ignored after the first chunk
      step();
      in_valid  = 1'b0;
      in_data   = 12'h5A5;
    end
    check({tag, "_ov"},   32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data),  32'(v.exp_data));
    check({tag, "_ovf"},  32'(out_ovf),   32'(OVF_EN ? v.exp_ovf : 1'b0));
    check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_post_ov"},  32'(out_valid), 32'd0);
    check({tag, "_post_rdy"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    //           d0     p0 s  n d1     p1 gap exp      ovf
    vecs[0]  = '{12'h800, 0, 1, 1, 12'h000, 0, 0, 16'hF800, 0};
    vecs[1]  = '{12'h800, 0, 0, 1, 12'h000, 0, 0, 16'h0800, 0};
    vecs[2]  = '{12'h001, 1, 1, 2, 12'h234, 0, 0, 16'h1234, 0};
    vecs[3]  = '{12'h0FF, 1, 1, 2, 12'h000, 0, 0, 16'hF000, 1};
    vecs[4]  = '{12'h00F, 1, 0, 2, 12'h123, 0, 2, 16'hF123, 0};
    vecs[5]  = '{12'h010, 1, 0, 2, 12'h000, 0, 0, 16'h0000, 1};
    vecs[6]  = '{12'hFFF, 1, 1, 2, 12'h800, 0, 1, 16'hF800, 0};
    vecs[7]  = '{12'h000, 1, 1, 2, 12'h800, 0, 0, 16'h0800, 0};
    vecs[8]  = '{12'hFFF, 0, 0, 1, 12'h000, 0, 0, 16'h0FFF, 0};
    vecs[9]  = '{12'h7FF, 0, 1, 1, 12'h000, 0, 0, 16'h07FF, 0};
    vecs[10] = '{12'h000, 1, 1, 2, 12'h001, 1, 0, 16'h0001, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_prefix = 1'b0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_ov",   32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data),  32'd0);
    check("rst_ovf",  32'(out_ovf),   32'd0);
    check("rst_rdy",  32'(in_ready),  32'd1);
    step();

    for (int i = 0; i < 11; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Forced termination with back-pressure on the output.
    in_valid = 1'b1; in_data = 12'h000; in_prefix = 1'b1; in_signed = 1'b1;
    step();
    in_data = 12'h001; in_prefix = 1'b1; in_signed = 1'b1;
    step();
    in_data = 12'h555; in_prefix = 1'b0; in_signed = 1'b0;  // offered while not ready
    check("bp_ov",   32'(out_valid), 32'd1);
    check("bp_data", 32'(out_data),  32'h0001);
    check("bp_ovf",  32'(out_ovf),   32'(OVF_EN));
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("bp_stall%0d_rdy", c),  32'(in_ready),  32'd0);
      check($sformatf("bp_stall%0d_ov", c),   32'(out_valid), 32'd1);
      check($sformatf("bp_stall%0d_data", c), 32'(out_data),  32'h0001);
      check($sformatf("bp_stall%0d_ovf", c),  32'(out_ovf),   32'(OVF_EN));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_post_rdy", 32'(in_ready),  32'd1);
    check("bp_post_ov",  32'(out_valid), 32'd0);

    // Reset in the middle of an immediate discards it.
    in_valid = 1'b1; in_data = 12'h001; in_prefix = 1'b1; in_signed = 1'b1;
    step();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_ov",  32'(out_valid), 32'd0);
    check("mrst_rdy", 32'(in_ready),  32'd1);
    step();
    check("mrst_ov2", 32'(out_valid), 32'd0);
    run_vec("mrst_v", '{12'h7FF, 0, 1, 1, 12'h000, 0, 0, 16'h07FF, 0});

    // Reset while holding a result overrides the pending handshake.
    in_valid = 1'b1; in_data = 12'h800; in_prefix = 1'b0; in_signed = 1'b1;
    step();
    in_valid = 1'b0;
    check("hrst_pre_ov", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("hrst_ov",   32'(out_valid), 32'd0);
    check("hrst_data", 32'(out_data),  32'd0);
    check("hrst_rdy",  32'(in_ready),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
